// File: rtl/mem_access_bridge_if.sv
// CPU load/store request bundle plus the single-port word memory bus.
interface mem_access_bridge_if #(parameter int ADDR_W = 13);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              err;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_d_in;
    logic [31:0]       mem_d_out;

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_d_out,
        input  rdata, ready, err, mem_w_en, mem_addr, mem_d_in
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_d_out,
        output rdata, ready, err, mem_w_en, mem_addr, mem_d_in
    );
endinterface

// File: rtl/mem_access_bridge.sv
// Byte/half/word load-store bridge onto a single-port word memory.
// Optional one-entry last-word load cache: define LAST_WORD_CACHE_EN.
module mem_access_bridge #(
    parameter int ADDR_W = 13
) (
    input logic clk,
    input logic rst,
    mem_access_bridge_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        WR,
        RMW_ISSUE,
        RMW_MERGE,
        RMW_WR,
        ERR
`ifdef LAST_WORD_CACHE_EN
        , HIT
`endif
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;
    logic              ready_q;
    logic              err_q;

    logic              misalign;
    logic [ADDR_W-1:0] word_in;
    logic [4:0]        sh;
    logic [31:0]       load_src;
    logic [31:0]       lane;
    logic [31:0]       load_val;
    logic [31:0]       lane_mask;
    logic [31:0]       merged;
    logic              load_done;
    logic              unused_addr;

    assign word_in     = bus.addr[ADDR_W+1:2];
    assign unused_addr = ^bus.addr[31:ADDR_W+2];

    always_comb begin
        misalign = 1'b0;
        unique case (1'b1)
            bus.size == 2'b11: misalign = 1'b1;
            bus.size == 2'b10: misalign = |bus.addr[1:0];
            bus.size == 2'b01: misalign = bus.addr[0];
            default:           misalign = 1'b0;
        endcase
    end

`ifdef LAST_WORD_CACHE_EN
    logic              c_valid;
    logic [ADDR_W-1:0] c_tag;
    logic [31:0]       c_data;
    logic              c_hit;

    assign c_hit     = c_valid && (word_in == c_tag);
    assign load_src  = (state == HIT) ? c_data : bus.mem_d_out;
    assign load_done = (state == RD_DATA) || (state == HIT);

    // Fill on every memory load; drop on any accepted store to the same word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_tag   <= '0;
            c_data  <= '0;
        end else begin
            if (state == RD_DATA) begin
                c_valid <= 1'b1;
                c_tag   <= addr_q[ADDR_W+1:2];
                c_data  <= bus.mem_d_out;
            end
            if (state == IDLE && bus.req && bus.we && !misalign && c_hit)
                c_valid <= 1'b0;
        end
    end
`else
    assign load_src  = bus.mem_d_out;
    assign load_done = (state == RD_DATA);
`endif

    assign sh   = {addr_q[1:0], 3'b000};
    assign lane = load_src >> sh;

    always_comb begin
        load_val = lane;
        unique case (size_q)
            2'b00:   load_val = {{24{sext_q & lane[7]}}, lane[7:0]};
            2'b01:   load_val = {{16{sext_q & lane[15]}}, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign merged    = (bus.mem_d_out & ~lane_mask) | ((wdata_q << sh) & lane_mask);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    if (misalign) begin
                        state_nxt = ERR;
                    end else if (!bus.we) begin
`ifdef LAST_WORD_CACHE_EN
                        state_nxt = c_hit ? HIT : RD_ISSUE;
`else
                        state_nxt = RD_ISSUE;
`endif
                    end else if (bus.size == 2'b10) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RMW_ISSUE;
                    end
                end
            end
            RD_ISSUE:  state_nxt = RD_DATA;
            RMW_ISSUE: state_nxt = RMW_MERGE;
            RMW_MERGE: state_nxt = RMW_WR;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            if (state == IDLE && bus.req) begin
                addr_q  <= bus.addr[ADDR_W+1:0];
                size_q  <= bus.size;
                sext_q  <= bus.sign_ext;
                wdata_q <= bus.wdata;
            end
            if (state == RMW_MERGE)
                merge_q <= merged;
            if (load_done) begin
                rdata_q <= load_val;
                ready_q <= 1'b1;
            end
            if (state == WR || state == RMW_WR)
                ready_q <= 1'b1;
            if (state == ERR) begin
                rdata_q <= '0;
                ready_q <= 1'b1;
                err_q   <= 1'b1;
            end
        end
    end

    assign bus.mem_w_en = (state == WR) || (state == RMW_WR);
    assign bus.mem_addr = addr_q[ADDR_W+1:2];
    assign bus.mem_d_in = (state == RMW_WR) ? merge_q : wdata_q;
    assign bus.rdata    = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_access_bridge.sv
// Bench for mem_access_bridge: directed steps then random traffic
// against a byte-array memory model (honours LAST_WORD_CACHE_EN).
module tb_mem_access_bridge;
    localparam int ADDR_W = 13;
`ifdef LAST_WORD_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic clk;
    logic rst;
    int   ncmp;
    int   nfail;

    logic [7:0]  rb [0:63];
    logic [31:0] exp_rdata;
    bit          cv;
    int          ct;

    logic [31:0] mem [0:8191];

    mem_access_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: output register only loads on non-write cycles.
    always @(posedge clk) begin
        if (bus.mem_w_en) mem[bus.mem_addr] <= bus.mem_d_in;
        else              bus.mem_d_out     <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input string tag);
        int a, n, lat, writes, expl, expw;
        bit e;
        logic [31:0] v;
        a = int'(ad % 32'd32768);
        n = 1 << sz;
        e = (sz == 2'd3) || (sz == 2'd1 && ad[0]) ||
            (sz == 2'd2 && ad[1:0] != 2'd0);
        if (e) begin
            expl = 1;
            expw = 0;
            exp_rdata = 32'd0;
        end else if (!w) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(rb[a+i]) << (8 * i));
            if (sx && n < 4 && rb[a+n-1][7]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            exp_rdata = v;
            expw = 0;
            if (CACHE && cv && ct == a / 4) begin
                expl = 1;
            end else begin
                expl = 2;
                if (CACHE) begin
                    cv = 1'b1;
                    ct = a / 4;
                end
            end
        end else begin
            expl = (n == 4) ? 1 : 3;
            expw = 1;
            for (int i = 0; i < n; i++) rb[a+i] = wd[8*i +: 8];
            if (cv && ct == a / 4) cv = 1'b0;
        end

        bus.req      = 1'b1;
        bus.we       = w;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.addr     = ad;
        bus.wdata    = wd;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        lat = 0;
        writes = 0;
        while (lat < 8) begin
            if (bus.mem_w_en) writes++;
            @(posedge clk);
            #1;
            lat++;
            if (bus.ready) break;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(expl));
        chk({tag, "/err"}, 32'(bus.err), 32'(e));
        chk({tag, "/rdata"}, bus.rdata, exp_rdata);
        chk({tag, "/writes"}, 32'(writes), 32'(expw));
    endtask

    task automatic idle_chk(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "/ready_low"}, 32'(bus.ready), 32'd0);
        chk({tag, "/err_low"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        ncmp = 0;
        nfail = 0;
        cv = 1'b0;
        ct = 0;
        exp_rdata = 32'd0;
        bus.req = 1'b0;
        bus.we = 1'b0;
        bus.size = 2'd0;
        bus.sign_ext = 1'b0;
        bus.addr = 32'd0;
        bus.wdata = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/ready", 32'(bus.ready), 32'd0);
        chk("reset/err", 32'(bus.err), 32'd0);
        chk("reset/rdata", bus.rdata, 32'd0);
        chk("reset/mem_w_en", 32'(bus.mem_w_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++)
            txn(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "init");
        txn(1'b1, 2'd2, 1'b0, 32'h14, 32'h8899_AABB, "init_w5");
        txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, "init_w8");

        txn(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, "ld_word");
        idle_chk("ld_word");
        txn(1'b1, 2'd0, 1'b0, 32'h15, 32'h0000_00CC, "st_byte");
        txn(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, "ld_after_st");
        txn(1'b0, 2'd0, 1'b1, 32'h17, 32'd0, "lb_sext");
        txn(1'b0, 2'd0, 1'b0, 32'h17, 32'd0, "lb_zext");
        txn(1'b0, 2'd1, 1'b1, 32'h16, 32'd0, "lh_sext");
        txn(1'b0, 2'd1, 1'b0, 32'h13, 32'd0, "lh_misalign");
        txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, "st_after_err");
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "ld_w4");
        txn(1'b1, 2'd3, 1'b0, 32'h18, 32'hDEAD_BEEF, "st_size3");
        txn(1'b1, 2'd2, 1'b0, 32'h1A, 32'hDEAD_BEEF, "sw_misalign");
        txn(1'b1, 2'd1, 1'b0, 32'h1A, 32'h0000_A55A, "sh_hi");
        txn(1'b0, 2'd2, 1'b0, 32'h8018, 32'd0, "ld_alias");

        txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, "pre_rst_w8");
        bus.req = 1'b1;
        bus.we = 1'b1;
        bus.size = 2'd1;
        bus.addr = 32'h20;
        bus.wdata = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cv = 1'b0;
        exp_rdata = 32'd0;
        #1;
        chk("rmw_rst/mem_w_en", 32'(bus.mem_w_en), 32'd0);
        chk("rmw_rst/ready", 32'(bus.ready), 32'd0);
        chk("rmw_rst/err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1;
        chk("rmw_rst/mem_w_en_hold", 32'(bus.mem_w_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, "rmw_rst/ld_w8");

        txn(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, "cache_ld1");
        txn(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, "cache_ld2");
        txn(1'b1, 2'd2, 1'b0, 32'h14, 32'h0BAD_CAFE, "cache_st");
        txn(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, "cache_ld3");
        txn(1'b0, 2'd0, 1'b1, 32'h17, 32'd0, "cache_lb");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ad;
            ad = ($urandom & 32'hFFFF_8000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) ad[1:0] = 2'd0;
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ad, $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/mem_access_bridge.md
Name: mem_access_bridge

Overview:
Sits between the CPU load/store unit and the unified 8192x32 word memory. That memory has a single port, a synchronous read whose output register updates only on non-write cycles, and no byte enables. This block turns byte-addressed byte/half/word requests into word accesses. It absorbs the 1-cycle read latency, performs read-modify-write for sub-word stores, and aligns and extends loaded data.

Parameters:
ADDR_W, 13, memory word-address width; byte address bits [ADDR_W+1:2] select the word.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  CPU request; sampled only in IDLE
we  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word, 11 reserved
sign_ext  in  1  loads: 1 = sign-extend, 0 = zero-extend
addr  in  32  byte address
wdata  in  32  store data, right-justified
rdata  out  32  load result, registered
ready  out  1  one-cycle completion pulse, registered
err  out  1  one-cycle error pulse, coincident with ready
mem_w_en  out  1  memory write enable
mem_addr  out  ADDR_W  memory word address
mem_d_in  out  32  memory write data
mem_d_out  in  32  memory read data; valid the cycle after a non-write address cycle

Behaviour:
- Reset (async): state=IDLE, rdata=0, ready=0, err=0, latched request regs=0. mem_w_en is decoded from state, so it drops to 0 immediately. Reset before RMW_WR leaves memory unchanged.
- Little-endian lanes: byte offset n occupies bits [8n+7:8n].
- Address bits above ADDR_W+1 are ignored, so 0x8000 aliases 0x0000.
- In IDLE, when req=1 the block latches addr, we, size, sign_ext and wdata, then branches:
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11: go to ERR. No memory access.
  - Load: go to RD_ISSUE.
  - Word store: go to WR.
  - Byte/half store: go to RMW_ISSUE.
- RD_ISSUE: mem_addr = latched word address, mem_w_en=0. Next state RD_DATA.
- RD_DATA: extract the lane from mem_d_out, extend per sign_ext, load rdata, set ready. Next state IDLE.
- WR: mem_w_en=1, mem_d_in=wdata. Set ready. Next state IDLE.
- RMW_ISSUE: read the target word (mem_w_en=0). Next state RMW_MERGE.
- RMW_MERGE: merge register = mem_d_out with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Next state RMW_WR.
- RMW_WR: mem_w_en=1, mem_d_in=merge register. Set ready. Next state IDLE.
- ERR: set ready and err, rdata=0. Next state IDLE.
- Outside the listed states, mem_w_en=0. mem_addr always reflects the latched address.
- ready and err are high for exactly one cycle; the block is in IDLE during that cycle.
- Back-to-back: req=1 in the ready cycle starts a new transaction. The CPU must drop req in the ready cycle if it has no new request.
- Latency, counting from the edge that samples req at k:
  - ready is high after edge k+2 for a load.
  - ready is high after edge k+1 for a word store or an error.
  - ready is high after edge k+3 for a sub-word store.
- rdata holds its value until the next load completes or an error occurs. Stores do not modify rdata.

Optional Feature:
LAST_WORD_CACHE_EN
- Defined: a one-entry register holds {valid, word address, data}, filled on every RD_DATA.
  - A load whose word address matches a valid entry goes IDLE -> HIT and completes from the entry. ready is high after edge k+1 and there is no memory access.
  - Any store to the cached word address clears valid, on the same edge that enters WR or RMW_ISSUE.
  - Reset clears valid.
- Undefined: no entry and no HIT state. All loads take the full path.

Test Plan:
1. Memory word 5 = 0x8899AABB. Load word at addr 0x14 -> after 2 edges rdata=0x8899AABB, ready pulse 1 cycle, err=0.
2. Byte store wdata=0x000000CC to addr 0x15, then word load at 0x14 -> memory word 5 = 0x8899CCBB. Exactly one mem_w_en cycle, preceded by a read cycle.
3. Word 5 = 0x8899CCBB, load byte at addr 0x17:
   - sign_ext=1 -> rdata=0xFFFFFF88.
   - sign_ext=0 -> rdata=0x00000088.
   - Half load at addr 0x16 with sign_ext=1 -> rdata=0xFFFF8899.
4. Half load at addr 0x13 -> ready and err both high after 1 edge, rdata=0, mem_w_en never 1. A following store to word 4 completes normally.
5. Assert rst during RMW_MERGE of a half store to addr 0x20 (word 8 = 0x12345678) -> mem_w_en stays 0, word 8 still reads 0x12345678, ready=err=0.
6. With LAST_WORD_CACHE_EN defined:
   - Load 0x14 twice -> second load gives ready after 1 edge, no mem read cycle.
   - Store to 0x14, then load 0x14 -> full 2-edge path, new data returned.
